// File: rtl/risc_v_mike_gpio_debounce_pkg.sv
// Shared constants and types for the GPIO input conditioning stage.
package risc_v_mike_pkg;

    localparam int GPIO_BYTE           = 8;
    localparam int GPIO_DB_CYCLES_DEF  = 16;

    typedef logic [GPIO_BYTE-1:0] gpio_vec_t;

endpackage

// File: rtl/risc_v_mike_gpio_debounce_if.sv
// Bundle of pad, MMIO control and conditioned-output signals for the debounce stage.
interface risc_v_mike_gpio_debounce_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] gpio_pad_in;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] gpio_db;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic [WIDTH-1:0] edge_status;
    logic             gpio_irq;

    // Side that drives pads and register controls (MMIO decode / bench).
    modport master (
        output gpio_pad_in,
        output edge_clr,
        output irq_en,
        input  gpio_db,
        input  rise_pulse,
        input  fall_pulse,
        input  edge_status,
        input  gpio_irq
    );

    // Side implemented by the debounce block.
    modport slave (
        input  gpio_pad_in,
        input  edge_clr,
        input  irq_en,
        output gpio_db,
        output rise_pulse,
        output fall_pulse,
        output edge_status,
        output gpio_irq
    );

endinterface

// File: rtl/risc_v_mike_gpio_debounce_bit.sv
// One GPIO input bit: 2-FF synchronizer, stability counter, accepted level and edge pulses.
module risc_v_mike_debounce_bit
    import risc_v_mike_pkg::*;
#(
    parameter int DB_CYCLES = GPIO_DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pad,
    output logic o_db,
    output logic o_rise,
    output logic o_fall,
    output logic o_rise_next,
    output logic o_fall_next
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_db;
    logic             r_rise;
    logic             r_fall;

    logic             w_differs;
    logic             w_accept;

    // A new level is accepted on the edge that completes DB_CYCLES differing samples.
    always_comb begin
        w_differs   = (r_s2 != r_db);
        w_accept    = w_differs && (r_cnt == CNT_LAST);
        o_rise_next = w_accept &&  r_s2;
        o_fall_next = w_accept && !r_s2;
    end

    // Synchronize the pad, qualify it, and register the accepted level and its pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_cnt  <= '0;
            r_db   <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_s1   <= i_pad;
            r_s2   <= r_s1;
            r_rise <= o_rise_next;
            r_fall <= o_fall_next;
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_db  <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_db   = r_db;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/risc_v_mike_gpio_debounce.sv
// GPIO input conditioning: per-bit debounce, sticky W1C edge flags and a maskable interrupt.
module risc_v_mike_gpio_debounce
    import risc_v_mike_pkg::*;
#(
    parameter int WIDTH     = GPIO_BYTE,
    parameter int DB_CYCLES = GPIO_DB_CYCLES_DEF
) (
    input logic                        clk,
    input logic                        rst,
    risc_v_mike_gpio_debounce_if.slave bus
);

    logic [WIDTH-1:0] w_db;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_rise_next;
    logic [WIDTH-1:0] w_fall_next;
    logic [WIDTH-1:0] w_status_next;

    logic [WIDTH-1:0] r_edge_status;
    logic             r_irq;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            risc_v_mike_debounce_bit #(
                .DB_CYCLES (DB_CYCLES)
            ) u_bit (
                .clk         (clk),
                .rst         (rst),
                .i_pad       (bus.gpio_pad_in[gi]),
                .o_db        (w_db[gi]),
                .o_rise      (w_rise[gi]),
                .o_fall      (w_fall[gi]),
                .o_rise_next (w_rise_next[gi]),
                .o_fall_next (w_fall_next[gi])
            );
        end
    endgenerate

    // New events are OR'd in after the clear so a same-cycle clear never loses an event.
    always_comb begin
        w_status_next = (r_edge_status & ~bus.edge_clr) | w_rise_next | w_fall_next;
    end

    // Sticky flags and the interrupt both register from the next-state value, so they move together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_edge_status <= '0;
            r_irq         <= 1'b0;
        end else begin
            r_edge_status <= w_status_next;
            r_irq         <= |(w_status_next & bus.irq_en);
        end
    end

    assign bus.gpio_db     = w_db;
    assign bus.rise_pulse  = w_rise;
    assign bus.fall_pulse  = w_fall;
    assign bus.edge_status = r_edge_status;
    assign bus.gpio_irq    = r_irq;

endmodule

// File: tb/tb_risc_v_mike_gpio_debounce.sv
// Bench for the GPIO debounce stage: directed scenarios plus randomized traffic against a window model.
module tb_risc_v_mike_gpio_debounce;
    import risc_v_mike_pkg::*;

    localparam int WIDTH = GPIO_BYTE;
    localparam int DB    = 4;

    logic clk;
    logic rst;
    int   checks;
    int   passes;
    logic cmpOn;

    risc_v_mike_gpio_debounce_if #(.WIDTH(WIDTH)) dbIf ();

    risc_v_mike_gpio_debounce #(
        .WIDTH     (WIDTH),
        .DB_CYCLES (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dbIf)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a level is accepted once the last DB synchronized samples all disagree with it.
    gpio_vec_t mS1 = '0, mS2 = '0, mDb = '0, mRise = '0, mFall = '0, mEs = '0;
    logic      mIrq = 1'b0;
    logic [DB-1:0] mHist [WIDTH];

    always @(posedge clk) begin
        gpio_vec_t newR;
        gpio_vec_t newF;
        newR = '0;
        newF = '0;
        if (rst) begin
            mS1 = '0; mS2 = '0; mDb = '0; mRise = '0; mFall = '0; mEs = '0; mIrq = 1'b0;
            for (int b = 0; b < WIDTH; b++) mHist[b] = '0;
        end else begin
            for (int b = 0; b < WIDTH; b++) begin
                mHist[b] = {mHist[b][DB-2:0], mS2[b]};
                if (mHist[b] == {DB{~mDb[b]}}) begin
                    mDb[b] = ~mDb[b];
                    if (mDb[b]) newR[b] = 1'b1;
                    else        newF[b] = 1'b1;
                end
            end
            mS2   = mS1;
            mS1   = dbIf.gpio_pad_in;
            mRise = newR;
            mFall = newF;
            mEs   = (mEs & ~dbIf.edge_clr) | newR | newF;
            mIrq  = |(mEs & dbIf.irq_en);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Every cycle, away from the active edge, compare all outputs with the model.
    always @(negedge clk) begin
        if (cmpOn) begin
            checkOutput("model_db",     32'(dbIf.gpio_db),     32'(mDb));
            checkOutput("model_rise",   32'(dbIf.rise_pulse),  32'(mRise));
            checkOutput("model_fall",   32'(dbIf.fall_pulse),  32'(mFall));
            checkOutput("model_status", 32'(dbIf.edge_status), 32'(mEs));
            checkOutput("model_irq",    32'(dbIf.gpio_irq),    32'(mIrq));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input gpio_vec_t pad, input gpio_vec_t clr, input gpio_vec_t en);
        @(posedge clk);
        #1;
        dbIf.gpio_pad_in = pad;
        dbIf.edge_clr    = clr;
        dbIf.irq_en      = en;
    endtask

    initial begin
        logic [6:0] pat;
        int         pulses;
        int         riseEdge;
        gpio_vec_t  pad;
        gpio_vec_t  en;

        checks = 0;
        passes = 0;
        cmpOn  = 1'b0;
        rst    = 1'b1;
        dbIf.gpio_pad_in = '0;
        dbIf.edge_clr    = '0;
        dbIf.irq_en      = '0;
        step(2);
        cmpOn = 1'b1;
        rst   = 1'b0;
        checkOutput("reset_db",     32'(dbIf.gpio_db),     32'h00);
        checkOutput("reset_status", 32'(dbIf.edge_status), 32'h00);
        checkOutput("reset_irq",    32'(dbIf.gpio_irq),    32'h0);

        // Clean rise on bit0 lands after edge 6.
        applyStimulus(8'h01, 8'h00, 8'h01);
        step(5);
        checkOutput("s1_db_edge5",   32'(dbIf.gpio_db),     32'h00);
        step(1);
        checkOutput("s1_db_edge6",   32'(dbIf.gpio_db),     32'h01);
        checkOutput("s1_rise",       32'(dbIf.rise_pulse),  32'h01);
        checkOutput("s1_status",     32'(dbIf.edge_status), 32'h01);
        checkOutput("s1_irq",        32'(dbIf.gpio_irq),    32'h1);
        step(1);
        checkOutput("s1_rise_once",  32'(dbIf.rise_pulse),  32'h00);

        // Clear collides with a new fall on bit0; the event must win.
        applyStimulus(8'h00, 8'h00, 8'h01);
        step(5);
        dbIf.edge_clr = 8'h01;
        step(1);
        dbIf.edge_clr = 8'h00;
        checkOutput("s4_db",         32'(dbIf.gpio_db),     32'h00);
        checkOutput("s4_fall",       32'(dbIf.fall_pulse),  32'h01);
        checkOutput("s4_status",     32'(dbIf.edge_status), 32'h01);
        checkOutput("s4_irq",        32'(dbIf.gpio_irq),    32'h1);
        dbIf.edge_clr = 8'h01;
        step(1);
        dbIf.edge_clr = 8'h00;
        checkOutput("s4_cleared",    32'(dbIf.edge_status), 32'h00);
        checkOutput("s4_irq_low",    32'(dbIf.gpio_irq),    32'h0);

        // Three-cycle glitch on bit3 is rejected, four-cycle pulse is accepted both ways.
        applyStimulus(8'h08, 8'h00, 8'h01);
        step(3);
        dbIf.gpio_pad_in = 8'h00;
        step(10);
        checkOutput("s2_glitch_db",     32'(dbIf.gpio_db),     32'h00);
        checkOutput("s2_glitch_status", 32'(dbIf.edge_status), 32'h00);
        dbIf.gpio_pad_in = 8'h08;
        step(4);
        dbIf.gpio_pad_in = 8'h00;
        step(4);
        checkOutput("s2_pulse_high",    32'(dbIf.gpio_db),     32'h08);
        step(4);
        checkOutput("s2_pulse_low",     32'(dbIf.gpio_db),     32'h00);
        checkOutput("s2_pulse_status",  32'(dbIf.edge_status), 32'h08);

        // Bounce 1,1,0,1,1,1,1 on bit5: one rise, four stable samples after the last bounce.
        pat      = 7'b1111011;
        pulses   = 0;
        riseEdge = 0;
        dbIf.gpio_pad_in = {2'b00, pat[0], 5'b0};
        for (int e = 1; e <= 14; e++) begin
            step(1);
            if (dbIf.rise_pulse[5]) pulses++;
            if (dbIf.gpio_db[5] && riseEdge == 0) riseEdge = e;
            dbIf.gpio_pad_in = (e < 7) ? {2'b00, pat[e], 5'b0} : 8'h20;
        end
        checkOutput("s3_pulse_count", 32'(pulses),   32'd1);
        checkOutput("s3_rise_edge",   32'(riseEdge), 32'd9);

        // All pads rise together.
        applyStimulus(8'h00, 8'hFF, 8'hFF);
        step(1);
        dbIf.edge_clr = 8'h00;
        step(8);
        dbIf.edge_clr = 8'hFF;
        step(1);
        dbIf.edge_clr = 8'h00;
        applyStimulus(8'hFF, 8'h00, 8'hFF);
        step(5);
        checkOutput("s5_db_edge5", 32'(dbIf.gpio_db),    32'h00);
        step(1);
        checkOutput("s5_db",       32'(dbIf.gpio_db),    32'hFF);
        checkOutput("s5_rise",     32'(dbIf.rise_pulse), 32'hFF);
        checkOutput("s5_irq",      32'(dbIf.gpio_irq),   32'h1);
        step(1);
        checkOutput("s5_rise_off", 32'(dbIf.rise_pulse), 32'h00);

        // Reset while bit2 is mid-qualification, pad held high through and after it.
        applyStimulus(8'h00, 8'hFF, 8'hFF);
        step(8);
        dbIf.edge_clr = 8'h00;
        applyStimulus(8'h04, 8'h00, 8'hFF);
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checkOutput("s6_db",        32'(dbIf.gpio_db),     32'h00);
        checkOutput("s6_status",    32'(dbIf.edge_status), 32'h00);
        checkOutput("s6_irq",       32'(dbIf.gpio_irq),    32'h0);
        step(5);
        checkOutput("s6_db_early",  32'(dbIf.gpio_db),     32'h00);
        step(1);
        checkOutput("s6_db_rise",   32'(dbIf.gpio_db),     32'h04);
        checkOutput("s6_status_up", 32'(dbIf.edge_status), 32'h04);

        // Randomized traffic: sparse pad toggles, clears, enable changes and occasional reset.
        pad = 8'h04;
        en  = 8'hFF;
        for (int i = 0; i < 3000; i++) begin
            pad = pad ^ gpio_vec_t'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 49) == 0) en = gpio_vec_t'($urandom);
            applyStimulus(pad, ($urandom_range(0, 5) == 0) ? gpio_vec_t'($urandom) : 8'h00, en);
            rst = ($urandom_range(0, 299) == 0);
        end
        applyStimulus(pad, 8'h00, en);
        rst = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
